// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, synchronous IROM addressing and the IF/ID
// pipeline register, with load-use stall, EX redirect and a fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IROM_AW-1:0] irom_addr_o,
  input  logic [31:0]        irom_data_i,
  output logic [31:0]        id_inst_o,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_pc4_o,
  output logic               id_valid_o,
  output logic               misalign_o,
  output logic [31:0]        fetch_cnt_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_pc;
  logic        r_fv;
  logic [31:0] w_nxt_pc;
  logic [31:0] w_pc4;
  logic        w_load;

  assign w_pc4  = r_pc + 32'd4;
  assign w_load = !redirect_i && !stall_i;

  // NOTE: combinational logic uses blocking '=' with a default assigned first so
  // every path drives w_nxt_pc and no latch is inferred.
  always_comb begin
    w_nxt_pc = w_pc4;
    if (redirect_i)            w_nxt_pc = {redirect_pc_i[31:2], 2'b00};
    else if (stall_i || !r_fv) w_nxt_pc = r_pc;
  end

  // Reset forces the address so the first word is already in flight at E1.
  assign irom_addr_o = rst_i ? RESET_PC[IROM_AW+1:2] : w_nxt_pc[IROM_AW+1:2];

  // NOTE: sequential state uses non-blocking '<=' so all registers sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
      r_fv <= 1'b0;
    end else begin
      r_pc <= w_nxt_pc;
      r_fv <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP;
      id_pc_o    <= 32'd0;
      id_pc4_o   <= 32'd0;
    end else if (redirect_i) begin
      // The word on irom_data_i is wrong-path; replace it with a bubble.
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP;
      id_pc_o    <= 32'd0;
      id_pc4_o   <= 32'd0;
    end else if (!stall_i) begin
      id_valid_o <= r_fv;
      id_inst_o  <= r_fv ? irom_data_i : NOP;
      id_pc_o    <= r_pc;
      id_pc4_o   <= w_pc4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_o  <= 1'b0;
      fetch_cnt_o <= 32'd0;
    end else begin
      if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) misalign_o <= 1'b1;
      if (w_load && r_fv) fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a reference model pushes expected IF/ID state
// into a scoreboard queue each cycle, popped and compared after the clock edge.
module tb_if_stage;

  localparam int          AW  = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redir;
  logic [31:0]   redir_pc;
  logic [AW-1:0] irom_addr;
  logic [31:0]   irom_data;
  logic [31:0]   id_inst, id_pc, id_pc4, fetch_cnt;
  logic          id_valid, misalign;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] m_pc;
  logic        m_fv;

  if_stage #(.RESET_PC(32'h0000_0000), .IROM_AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(redir_pc), .irom_addr_o(irom_addr), .irom_data_i(irom_data),
    .id_inst_o(id_inst), .id_pc_o(id_pc), .id_pc4_o(id_pc4), .id_valid_o(id_valid),
    .misalign_o(misalign), .fetch_cnt_o(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Distinct, address-derived content for every IROM word.
  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return {2'b10, 14'h2A5B, a, 2'b11};
  endfunction

  always @(posedge clk) irom_data <= word_at(irom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_fv     = 1'b0;
    e.valid  = 1'b0;
    e.inst   = NOP;
    e.pc     = 32'h0;
    e.pc4    = 32'h0;
    e.cnt    = 32'h0;
    e.mis    = 1'b0;
  endtask

  // Starts at a falling edge, drives one cycle of stimulus, checks after the
  // rising edge and returns at the next falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] nxt;
    exp_t        got;
    stall = s; redir = r; redir_pc = t;
    if (r)              nxt = {t[31:2], 2'b00};
    else if (s || !m_fv) nxt = m_pc;
    else                nxt = m_pc + 32'd4;
    #1 check("irom_addr", {18'h0, irom_addr}, {18'h0, nxt[AW+1:2]});
    if (r) begin
      e.valid = 1'b0; e.inst = NOP; e.pc = 32'h0; e.pc4 = 32'h0;
      if (t[1:0] != 2'b00) e.mis = 1'b1;
    end else if (!s) begin
      e.valid = m_fv;
      e.inst  = m_fv ? word_at(m_pc[AW+1:2]) : NOP;
      e.pc    = m_pc;
      e.pc4   = m_pc + 32'd4;
      if (m_fv) e.cnt = e.cnt + 32'd1;
    end
    sb.push_back(e);
    m_pc = nxt;
    m_fv = 1'b1;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("id_valid", {31'h0, id_valid}, {31'h0, got.valid});
    check("id_inst", id_inst, got.inst);
    check("id_pc", id_pc, got.pc);
    check("id_pc4", id_pc4, got.pc4);
    check("fetch_cnt", fetch_cnt, got.cnt);
    check("misalign", {31'h0, misalign}, {31'h0, got.mis});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    #12;
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_inst", id_inst, NOP);
    check("rst_pc", id_pc, 32'h0);
    check("rst_cnt", fetch_cnt, 32'h0);
    check("rst_addr", {18'h0, irom_addr}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // E1..E4: IF/ID fills with PCs 0, 4, 8
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    check("plan_pc8", id_pc, 32'h8);
    check("plan_inst8", id_inst, word_at(14'd2));
    // Two stall cycles hold PC 8, then 12 loads with no skip/duplicate
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("stall_hold", id_pc, 32'h8);
    step(1'b0, 1'b0, 32'h0);
    check("stall_release", id_pc, 32'hC);
    check("stall_cnt", fetch_cnt, 32'd4);

    // Redirect to 0x40 while pc_q = 0x10
    step(1'b0, 1'b1, 32'h40);
    check("redir_bubble", {31'h0, id_valid}, 32'h0);
    check("redir_nop", id_inst, NOP);
    step(1'b0, 1'b0, 32'h0);
    check("redir_pc", id_pc, 32'h40);
    check("redir_inst", id_inst, word_at(14'h10));

    // Stall and redirect together: redirect wins
    step(1'b1, 1'b1, 32'h80);
    check("both_bubble", {31'h0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("both_pc", id_pc, 32'h80);

    // Misaligned redirect
    step(1'b0, 1'b1, 32'h22);
    step(1'b0, 1'b0, 32'h0);
    check("mis_pc", id_pc, 32'h20);
    check("mis_flag", {31'h0, misalign}, 32'h1);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_next", id_pc, 32'h0);

    // Random mix of stalls and redirects
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
    stall = 1'b0; redir = 1'b0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, id_valid}, 32'h0);
    check("arst_cnt", fetch_cnt, 32'h0);
    check("arst_mis", {31'h0, misalign}, 32'h0);
    check("arst_addr", {18'h0, irom_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 32'h0);
    check("restart_e1", {31'h0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("restart_e2_valid", {31'h0, id_valid}, 32'h1);
    check("restart_e2_inst", id_inst, word_at(14'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
